corr_window_sequencer: RTL
==========================

Name: corr_window_sequencer

Overview:
- Sequences one correlator counter datapath through windows. That datapath has four counters (X, Y, intersection, symmetric difference), a TIME_W-bit time input, a zero-counts input and a 1-cycle registered window weight.
- Drives the time index and the zero-counts pulse, inserts the flush cycle that the registered weight needs, and captures the four final counts into a result register.
- Presents results on a valid/ready interface, tagged with a window index and an overrun flag.
- Supports single-shot and continuous windowing under software start/stop control.

Parameters:
- DATA_W, 16, width of each count input and result output.
- TIME_W, 8, time index width; window length WINLEN = 1<<TIME_W samples.
- WINIDX_W, 8, width of the window sequence number attached to each result.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_start  input  1  begin windowing; ignored unless state is IDLE.
- i_continuous  input  1  sampled with i_start: 1 = back-to-back windows, 0 = single window.
- i_stop  input  1  finish the current window, then go IDLE; sticky until taken.
- i_countX  input  DATA_W  datapath countX.
- i_countY  input  DATA_W  datapath countY.
- i_countIsect  input  DATA_W  datapath intersection count.
- i_countSymdiff  input  DATA_W  datapath symmetric-difference count.
- o_t  output  TIME_W  window time index to datapath.
- o_zeroCounts  output  1  to datapath; clears its counters at the next edge.
- o_busy  output  1  state != IDLE, or a capture is pending.
- o_valid  output  1  result register holds an unconsumed result.
- i_ready  input  1  consumer accepts the result when o_valid & i_ready.
- o_resX  output  DATA_W  captured countX.
- o_resY  output  DATA_W  captured countY.
- o_resIsect  output  DATA_W  captured intersection count.
- o_resSymdiff  output  DATA_W  captured symmetric-difference count.
- o_winIdx  output  WINIDX_W  sequence number of the captured window; wraps modulo 2^WINIDX_W.
- o_overrun  output  1  sticky: a capture was lost because o_valid was still high.
- i_clrOverrun  input  1  clears o_overrun.

Behaviour:
- Reset: state IDLE, o_t=0, o_zeroCounts=0, o_valid=0, all o_res*=0, o_winIdx=0, o_overrun=0, internal capture flag=0, continuous latch=0, stop latch=0, window counter=0.
- Reset mid-window: abandons the window; no capture.
- States:
  - IDLE: o_t=0, o_zeroCounts=0. On i_start, latch i_continuous, clear the stop latch, go to RUN.
  - RUN: o_t counts 0..WINLEN-1, one per cycle. o_zeroCounts=1 exactly when o_t=0. After o_t=WINLEN-1, go to FLUSH.
  - FLUSH: one cycle, o_t=0, o_zeroCounts=0. The datapath applies the last weight in this cycle. A registered capture flag is set for the following cycle.
  - After FLUSH: go to RUN (o_t=0, o_zeroCounts=1) if continuous and the stop latch is clear; otherwise go to IDLE.
- Capture cycle (capture flag=1): the datapath counts are final in this cycle; the zero-counts clear lands at the next edge. At that edge:
  - If o_valid=0, or o_valid=1 and i_ready=1: load o_res* from i_count*, load o_winIdx from the window counter, set o_valid=1.
  - Otherwise: keep the old result, keep o_valid=1, set o_overrun=1.
  - The window counter increments on every capture, lost or not, so gaps in o_winIdx reveal drops.
- Handshake: o_valid falls at the edge where o_valid & i_ready and no capture occurs. o_res* are stable while o_valid=1.
- Timing: i_start sampled at edge s gives RUN at cycles s+1..s+WINLEN, FLUSH at s+WINLEN+1, capture cycle s+WINLEN+2, o_valid=1 from s+WINLEN+3. Continuous window period is WINLEN+1 cycles.
- i_stop: ORs into the stop latch in any non-IDLE state. Takes effect only at the FLUSH→next decision; a window is never truncated. In IDLE, i_stop is ignored.
- i_start and i_stop in the same IDLE cycle: start wins and the stop is discarded.
- i_clrOverrun in the same cycle as a new overrun: set wins.
- o_t is TIME_W bits and wraps naturally; WINLEN-1 is all-ones.

Test Plan:
- TIME_W=3, single-shot, i_start at edge 0, counts driven 5/6/7/8 in the capture cycle → o_zeroCounts only at cycle 1; o_t=0..7 over cycles 1..8; FLUSH cycle 9 with o_t=0; o_valid=1 at cycle 11 with res=5/6/7/8 and o_winIdx=0; state IDLE from cycle 10.
- Continuous, i_ready=1 → o_zeroCounts high every 9 cycles; o_winIdx=0,1,2,…; o_overrun stays 0.
- Continuous, i_ready=0 → first result held; o_overrun=1 after the second capture; once ready, o_winIdx=0 is accepted and the next capture delivers o_winIdx=2.
- i_stop asserted at o_t=3 of window 1 → window 1 completes, FLUSH, capture, then IDLE; no further o_zeroCounts; o_busy falls after the capture.
- i_rst_n pulled low at o_t=5 → all outputs return to 0 asynchronously; no o_valid after release.
- i_start while RUN, and simultaneous i_clrOverrun with a new overrun → start ignored with timing unchanged; o_overrun remains 1.

Source files
------------

// File: rtl/corr_window_sequencer.sv
// Window sequencer for a four-counter correlator datapath: drives the time index
// and zero-counts pulse, inserts the weight flush cycle, and captures final counts.
module corr_window_sequencer #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned TIME_W   = 8,
  parameter int unsigned WINIDX_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_continuous,
  input  logic                i_stop,
  input  logic [DATA_W-1:0]   i_countX,
  input  logic [DATA_W-1:0]   i_countY,
  input  logic [DATA_W-1:0]   i_countIsect,
  input  logic [DATA_W-1:0]   i_countSymdiff,
  output logic [TIME_W-1:0]   o_t,
  output logic                o_zeroCounts,
  output logic                o_busy,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [DATA_W-1:0]   o_resX,
  output logic [DATA_W-1:0]   o_resY,
  output logic [DATA_W-1:0]   o_resIsect,
  output logic [DATA_W-1:0]   o_resSymdiff,
  output logic [WINIDX_W-1:0] o_winIdx,
  output logic                o_overrun,
  input  logic                i_clrOverrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [TIME_W-1:0] T_LAST = '1;

  state_t              state;
  logic                cont_q;
  logic                stop_q;
  logic                cap;
  logic [WINIDX_W-1:0] win_cnt;
  logic                lost;

  // A capture is lost when the previous result is still held and not being taken.
  assign lost = cap && o_valid && !i_ready;

  // Window sequencing: time index, zero-counts pulse, flush and capture flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      o_t          <= '0;
      o_zeroCounts <= 1'b0;
      o_busy       <= 1'b0;
      cont_q       <= 1'b0;
      stop_q       <= 1'b0;
      cap          <= 1'b0;
    end else begin
      cap <= 1'b0;
      case (state)
        S_IDLE: begin
          o_t          <= '0;
          o_zeroCounts <= 1'b0;
          o_busy       <= 1'b0;
          if (i_start) begin
            state        <= S_RUN;
            cont_q       <= i_continuous;
            stop_q       <= 1'b0;
            o_zeroCounts <= 1'b1;
            o_busy       <= 1'b1;
          end
        end
        S_RUN: begin
          stop_q       <= stop_q | i_stop;
          o_busy       <= 1'b1;
          o_zeroCounts <= 1'b0;
          if (o_t == T_LAST) begin
            state <= S_FLUSH;
            o_t   <= '0;
          end else begin
            o_t <= o_t + TIME_W'(1);
          end
        end
        S_FLUSH: begin
          // Busy stays high through the capture cycle that follows.
          cap    <= 1'b1;
          o_busy <= 1'b1;
          o_t    <= '0;
          stop_q <= stop_q | i_stop;
          if (cont_q && !(stop_q || i_stop)) begin
            state        <= S_RUN;
            o_zeroCounts <= 1'b1;
          end else begin
            state        <= S_IDLE;
            o_zeroCounts <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          o_t          <= '0;
          o_zeroCounts <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

  // Result register, valid/ready handshake, window numbering and overrun flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_resX       <= '0;
      o_resY       <= '0;
      o_resIsect   <= '0;
      o_resSymdiff <= '0;
      o_winIdx     <= '0;
      o_overrun    <= 1'b0;
      win_cnt      <= '0;
    end else begin
      if (cap) begin
        if (!lost) begin
          o_resX       <= i_countX;
          o_resY       <= i_countY;
          o_resIsect   <= i_countIsect;
          o_resSymdiff <= i_countSymdiff;
          o_winIdx     <= win_cnt;
          o_valid      <= 1'b1;
        end
        win_cnt <= win_cnt + WINIDX_W'(1);
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (lost) begin
        o_overrun <= 1'b1;
      end else if (i_clrOverrun) begin
        o_overrun <= 1'b0;
      end
    end
  end

endmodule
